// File: rtl/instruction_decode_pipe.sv
// -----------------------------------------------------------------------------
// instruction_decode_pipe
//
// RV32I decode stage with a small skid FIFO of decoded entries. Each fetched
// word is decoded combinationally, the register-file selects are driven
// straight from inst, and on accept the decode result together with the
// register read data and PCs is written into the FIFO. The FIFO head drives
// every *_de output.
//
// Handshake (both sides): a transfer happens on a rising clk edge where
// valid and ready are both 1. A valid producer keeps valid high and its data
// stable until the transfer. in_ready may depend combinationally on
// out_ready (a full FIFO can accept while its head pops).
//
// Optional feature: macro DECODE_HAZARD_EN builds the load-use interlock
// (hazard check against held LOAD entries plus a one-cycle load shadow
// register). Without it the hazard term is constant 0.
//
// Parameters:
//   XLEN        datapath width (32 or 64)
//   SKID_DEPTH  buffered decoded entries (1 or 2)
//   OPLEN       width of decoded_op (at least 4)
//
// Ports:
//   clk, rst                synchronous active-high reset
//   flush                   discard held and incoming instructions
//   in_valid / in_ready     upstream handshake
//   inst, curr_pc_fd, next_pc_fd   fetched word and its PCs
//   rs1_sel, rs2_sel        combinational register-file selects
//   rs1_data_rd, rs2_data_rd       register-file read data
//   out_valid / out_ready   downstream handshake
//   imm, rs1_data_de, rs2_data_de, curr_pc_de, next_pc_de  head fields
//   funct_alu, rd_sel_de, decoded_op, illegal_de           head decode
//
// decoded_op encoding: 0 illegal, 1 LUI, 2 AUIPC, 3 JAL, 4 JALR, 5 BRANCH,
// 6 LOAD, 7 STORE, 8 OP_IMM, 9 OP, 10 MISC_MEM, 11 SYSTEM.
// -----------------------------------------------------------------------------
module instruction_decode_pipe #(
    parameter int XLEN       = 32,
    parameter int SKID_DEPTH = 2,
    parameter int OPLEN      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      inst,
    input  logic [XLEN-1:0]  curr_pc_fd,
    input  logic [XLEN-1:0]  next_pc_fd,
    output logic [4:0]       rs1_sel,
    output logic [4:0]       rs2_sel,
    input  logic [XLEN-1:0]  rs1_data_rd,
    input  logic [XLEN-1:0]  rs2_data_rd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm,
    output logic [XLEN-1:0]  rs1_data_de,
    output logic [XLEN-1:0]  rs2_data_de,
    output logic [XLEN-1:0]  curr_pc_de,
    output logic [XLEN-1:0]  next_pc_de,
    output logic [3:0]       funct_alu,
    output logic [4:0]       rd_sel_de,
    output logic [OPLEN-1:0] decoded_op,
    output logic             illegal_de
);

    localparam int CW = $clog2(SKID_DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(SKID_DEPTH);

    localparam logic [OPLEN-1:0] OP_ILLEGAL  = OPLEN'(0);
    localparam logic [OPLEN-1:0] OP_LUI      = OPLEN'(1);
    localparam logic [OPLEN-1:0] OP_AUIPC    = OPLEN'(2);
    localparam logic [OPLEN-1:0] OP_JAL      = OPLEN'(3);
    localparam logic [OPLEN-1:0] OP_JALR     = OPLEN'(4);
    localparam logic [OPLEN-1:0] OP_BRANCH   = OPLEN'(5);
    localparam logic [OPLEN-1:0] OP_LOAD     = OPLEN'(6);
    localparam logic [OPLEN-1:0] OP_STORE    = OPLEN'(7);
    localparam logic [OPLEN-1:0] OP_OPIMM    = OPLEN'(8);
    localparam logic [OPLEN-1:0] OP_OP       = OPLEN'(9);
    localparam logic [OPLEN-1:0] OP_MISCMEM  = OPLEN'(10);
    localparam logic [OPLEN-1:0] OP_SYSTEM   = OPLEN'(11);

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [XLEN-1:0]  rs1_data;
        logic [XLEN-1:0]  rs2_data;
        logic [XLEN-1:0]  curr_pc;
        logic [XLEN-1:0]  next_pc;
        logic [3:0]       funct_alu;
        logic [4:0]       rd_sel;
        logic [OPLEN-1:0] op;
        logic             illegal;
    } entry_t;

    // ---------------------------------------------------------------- decode
    logic [OPLEN-1:0] dec_op;
    logic [31:0]      imm32;
    entry_t           new_entry;

    always_comb begin
        dec_op = OP_ILLEGAL;
        imm32  = '0;
        // Full 7-bit match, so any word with inst[1:0] != 2'b11 falls to default.
        case (inst[6:0])
            7'b0110111: begin dec_op = OP_LUI;     imm32 = {inst[31:12], 12'b0}; end
            7'b0010111: begin dec_op = OP_AUIPC;   imm32 = {inst[31:12], 12'b0}; end
            7'b1101111: begin
                dec_op = OP_JAL;
                imm32  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            end
            7'b1100111: begin dec_op = OP_JALR;    imm32 = {{20{inst[31]}}, inst[31:20]}; end
            7'b1100011: begin
                dec_op = OP_BRANCH;
                imm32  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            end
            7'b0000011: begin dec_op = OP_LOAD;    imm32 = {{20{inst[31]}}, inst[31:20]}; end
            7'b0100011: begin dec_op = OP_STORE;   imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]}; end
            7'b0010011: begin dec_op = OP_OPIMM;   imm32 = {{20{inst[31]}}, inst[31:20]}; end
            7'b0110011: begin dec_op = OP_OP;      imm32 = '0; end
            7'b0001111: begin dec_op = OP_MISCMEM; imm32 = {{20{inst[31]}}, inst[31:20]}; end
            7'b1110011: begin dec_op = OP_SYSTEM;  imm32 = {{20{inst[31]}}, inst[31:20]}; end
            default:    begin dec_op = OP_ILLEGAL; imm32 = '0; end
        endcase
    end

    assign rs1_sel = (dec_op == OP_LUI) ? 5'd0 : inst[19:15];
    assign rs2_sel = inst[24:20];

    always_comb begin
        new_entry           = '0;
        new_entry.imm       = XLEN'($signed(imm32));
        new_entry.rs1_data  = rs1_data_rd;
        new_entry.rs2_data  = rs2_data_rd;
        new_entry.curr_pc   = curr_pc_fd;
        new_entry.next_pc   = next_pc_fd;
        new_entry.funct_alu = {inst[30], inst[14:12]};
        new_entry.rd_sel    = (dec_op == OP_STORE) ? 5'd0 : inst[11:7];
        new_entry.op        = dec_op;
        new_entry.illegal   = (dec_op == OP_ILLEGAL);
    end

    // ------------------------------------------------------------------ fifo
    entry_t         fifo_q [SKID_DEPTH];
    logic [CW-1:0]  count_q;
    logic [CW-1:0]  wr_pos;
    logic           pop;
    logic           push;
    logic           hazard;

    assign out_valid = (count_q != '0);
    assign pop       = out_valid & out_ready;
    assign push      = in_valid & in_ready;
    assign in_ready  = ((count_q != FULL) || pop) && !hazard && !flush && !rst;
    // A same-cycle pop frees the slot just below the current tail.
    assign wr_pos    = pop ? (count_q - CW'(1)) : count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            for (int i = 0; i < SKID_DEPTH; i++) fifo_q[i] <= '0;
        end else if (flush) begin
            // Entry contents are kept so the _de fields hold their last value.
            count_q <= '0;
        end else begin
            // Shift only occupied entries so an emptied head keeps its value.
            for (int i = 0; i < SKID_DEPTH - 1; i++) begin
                if (pop && (CW'(i + 1) < count_q)) fifo_q[i] <= fifo_q[i + 1];
            end
            for (int i = 0; i < SKID_DEPTH; i++) begin
                if (push && (CW'(i) == wr_pos)) fifo_q[i] <= new_entry;
            end
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    // ------------------------------------------------------- load-use hazard
`ifdef DECODE_HAZARD_EN
    logic       use_rs1;
    logic       use_rs2;
    logic [4:0] shadow_q;

    always_comb begin
        use_rs1 = (dec_op == OP_JALR) || (dec_op == OP_BRANCH) || (dec_op == OP_LOAD) ||
                  (dec_op == OP_STORE) || (dec_op == OP_OPIMM) || (dec_op == OP_OP);
        use_rs2 = (dec_op == OP_BRANCH) || (dec_op == OP_STORE) || (dec_op == OP_OP);
        hazard  = 1'b0;
        for (int i = 0; i < SKID_DEPTH; i++) begin
            if ((CW'(i) < count_q) && (fifo_q[i].op == OP_LOAD) && (fifo_q[i].rd_sel != 5'd0) &&
                ((use_rs1 && (fifo_q[i].rd_sel == inst[19:15])) ||
                 (use_rs2 && (fifo_q[i].rd_sel == inst[24:20]))))
                hazard = 1'b1;
        end
        if ((shadow_q != 5'd0) &&
            ((use_rs1 && (shadow_q == inst[19:15])) || (use_rs2 && (shadow_q == inst[24:20]))))
            hazard = 1'b1;
    end

    // Covers the cycle after a LOAD leaves, before its data is forwardable.
    always_ff @(posedge clk) begin
        if (rst || flush)                          shadow_q <= 5'd0;
        else if (pop && (fifo_q[0].op == OP_LOAD)) shadow_q <= fifo_q[0].rd_sel;
        else                                       shadow_q <= 5'd0;
    end
`else
    assign hazard = 1'b0;
`endif

    // --------------------------------------------------------------- outputs
    assign imm         = fifo_q[0].imm;
    assign rs1_data_de = fifo_q[0].rs1_data;
    assign rs2_data_de = fifo_q[0].rs2_data;
    assign curr_pc_de  = fifo_q[0].curr_pc;
    assign next_pc_de  = fifo_q[0].next_pc;
    assign funct_alu   = fifo_q[0].funct_alu;
    assign rd_sel_de   = fifo_q[0].rd_sel;
    assign decoded_op  = fifo_q[0].op;
    assign illegal_de  = fifo_q[0].illegal;

endmodule
